// File: rtl/mips_wb_arbiter.sv
// Writeback arbiter: shares the register file's single write port between the
// ALU (A) and load (B) requesters, each with a 1-entry hold buffer.
module mips_wb_arbiter #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              Write_Reg,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic              grant_b,
    output logic              busy
);

    typedef enum logic {
        PTR_A = 1'b0,
        PTR_B = 1'b1
    } ptr_e;

    localparam logic FIXED_PRIO = (PRIO_MODE == 1);

    logic              a_full_q, a_full_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [DATA_W-1:0] a_data_q, a_data_d;
    logic              b_full_q, b_full_d;
    logic [ADDR_W-1:0] b_addr_q, b_addr_d;
    logic [DATA_W-1:0] b_data_q, b_data_d;
    ptr_e              ptr_q, ptr_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic              grant_b_q, grant_b_d;

    logic grant_a_sel;
    logic grant_b_sel;
    logic a_load;
    logic b_load;

    // Arbitration looks only at buffer state, so ready never depends on valid.
    always_comb begin
        grant_a_sel = 1'b0;
        grant_b_sel = 1'b0;
        if (a_full_q && b_full_q) begin
            if (FIXED_PRIO || (ptr_q == PTR_B)) begin
                grant_b_sel = 1'b1;
            end else begin
                grant_a_sel = 1'b1;
            end
        end else begin
            grant_a_sel = a_full_q;
            grant_b_sel = b_full_q;
        end
    end

    assign a_ready = !reset && (!a_full_q || grant_a_sel);
    assign b_ready = !reset && (!b_full_q || grant_b_sel);

    // Address-0 transfers complete the handshake but are dropped here.
    assign a_load = a_valid && a_ready && (a_addr != '0);
    assign b_load = b_valid && b_ready && (b_addr != '0);

    always_comb begin
        a_full_d = a_full_q;
        a_addr_d = a_addr_q;
        a_data_d = a_data_q;
        if (a_load) begin
            a_full_d = 1'b1;
            a_addr_d = a_addr;
            a_data_d = a_data;
        end else if (grant_a_sel) begin
            a_full_d = 1'b0;
        end
    end

    always_comb begin
        b_full_d = b_full_q;
        b_addr_d = b_addr_q;
        b_data_d = b_data_q;
        if (b_load) begin
            b_full_d = 1'b1;
            b_addr_d = b_addr;
            b_data_d = b_data;
        end else if (grant_b_sel) begin
            b_full_d = 1'b0;
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        wr_d      = 1'b0;
        w_addr_d  = w_addr_q;
        w_data_d  = w_data_q;
        grant_b_d = grant_b_q;
        if (grant_a_sel) begin
            ptr_d     = PTR_B;
            wr_d      = 1'b1;
            w_addr_d  = a_addr_q;
            w_data_d  = a_data_q;
            grant_b_d = 1'b0;
        end else if (grant_b_sel) begin
            ptr_d     = PTR_A;
            wr_d      = 1'b1;
            w_addr_d  = b_addr_q;
            w_data_d  = b_data_q;
            grant_b_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_full_q  <= 1'b0;
            a_addr_q  <= '0;
            a_data_q  <= '0;
            b_full_q  <= 1'b0;
            b_addr_q  <= '0;
            b_data_q  <= '0;
            ptr_q     <= PTR_A;
            wr_q      <= 1'b0;
            w_addr_q  <= '0;
            w_data_q  <= '0;
            grant_b_q <= 1'b0;
        end else begin
            a_full_q  <= a_full_d;
            a_addr_q  <= a_addr_d;
            a_data_q  <= a_data_d;
            b_full_q  <= b_full_d;
            b_addr_q  <= b_addr_d;
            b_data_q  <= b_data_d;
            ptr_q     <= ptr_d;
            wr_q      <= wr_d;
            w_addr_q  <= w_addr_d;
            w_data_q  <= w_data_d;
            grant_b_q <= grant_b_d;
        end
    end

    assign Write_Reg = wr_q;
    assign W_Addr    = w_addr_q;
    assign W_Data    = w_data_q;
    assign grant_b   = grant_b_q;
    assign busy      = a_full_q || b_full_q || wr_q;

endmodule

// File: tb/tb_mips_wb_arbiter.sv
// Directed bench for mips_wb_arbiter: round-robin and fixed-priority instances
// plus a small register-file model fed by the round-robin instance.
module tb_mips_wb_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        r_reset, r_a_valid, r_a_ready, r_b_valid, r_b_ready;
    logic        r_wr, r_grant_b, r_busy;
    logic [4:0]  r_a_addr, r_b_addr, r_waddr;
    logic [31:0] r_a_data, r_b_data, r_wdata;

    logic        f_reset, f_a_valid, f_a_ready, f_b_valid, f_b_ready;
    logic        f_wr, f_grant_b, f_busy;
    logic [4:0]  f_a_addr, f_b_addr, f_waddr;
    logic [31:0] f_a_data, f_b_data, f_wdata;

    mips_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .PRIO_MODE(0)) dut_rr (
        .clk(clk), .reset(r_reset),
        .a_valid(r_a_valid), .a_ready(r_a_ready), .a_addr(r_a_addr), .a_data(r_a_data),
        .b_valid(r_b_valid), .b_ready(r_b_ready), .b_addr(r_b_addr), .b_data(r_b_data),
        .Write_Reg(r_wr), .W_Addr(r_waddr), .W_Data(r_wdata),
        .grant_b(r_grant_b), .busy(r_busy)
    );

    mips_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .PRIO_MODE(1)) dut_fp (
        .clk(clk), .reset(f_reset),
        .a_valid(f_a_valid), .a_ready(f_a_ready), .a_addr(f_a_addr), .a_data(f_a_data),
        .b_valid(f_b_valid), .b_ready(f_b_ready), .b_addr(f_b_addr), .b_data(f_b_data),
        .Write_Reg(f_wr), .W_Addr(f_waddr), .W_Data(f_wdata),
        .grant_b(f_grant_b), .busy(f_busy)
    );

    logic [31:0] rf [32];
    always @(posedge clk) if (r_wr) rf[r_waddr] <= r_wdata;

    task automatic reset_rr();
        r_reset = 1'b1; r_a_valid = 1'b0; r_b_valid = 1'b0;
        r_a_addr = '0; r_b_addr = '0; r_a_data = '0; r_b_data = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        r_reset = 1'b0;
    endtask

    task automatic reset_fp();
        f_reset = 1'b1; f_a_valid = 1'b0; f_b_valid = 1'b0;
        f_a_addr = '0; f_b_addr = '0; f_a_data = '0; f_b_data = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        f_reset = 1'b0;
    endtask

    task automatic test_reset();
        r_reset = 1'b1; r_a_valid = 1'b1; r_b_valid = 1'b1;
        r_a_addr = 5'd3; r_b_addr = 5'd4; r_a_data = 32'h33; r_b_data = 32'h44;
        f_reset = 1'b1; f_a_valid = 1'b1; f_b_valid = 1'b1;
        f_a_addr = 5'd3; f_b_addr = 5'd4; f_a_data = 32'h33; f_b_data = 32'h44;
        @(posedge clk); #1;
        checks++; if (r_a_ready !== 1'b0) begin errors++; $display("FAIL reset_rr_a_ready: got %b expected 0", r_a_ready); end
        checks++; if (r_b_ready !== 1'b0) begin errors++; $display("FAIL reset_rr_b_ready: got %b expected 0", r_b_ready); end
        checks++; if (f_a_ready !== 1'b0 || f_b_ready !== 1'b0) begin errors++; $display("FAIL reset_fp_ready: got %b%b expected 00", f_a_ready, f_b_ready); end
        @(posedge clk); #1;
        checks++; if (r_wr !== 1'b0) begin errors++; $display("FAIL reset_write_reg: got %b expected 0", r_wr); end
        checks++; if (r_waddr !== 5'd0) begin errors++; $display("FAIL reset_w_addr: got %0d expected 0", r_waddr); end
        checks++; if (r_wdata !== 32'd0) begin errors++; $display("FAIL reset_w_data: got %h expected 0", r_wdata); end
        checks++; if (r_grant_b !== 1'b0) begin errors++; $display("FAIL reset_grant_b: got %b expected 0", r_grant_b); end
        checks++; if (r_busy !== 1'b0 || f_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b%b expected 00", r_busy, f_busy); end
        r_a_valid = 1'b0; r_b_valid = 1'b0; f_a_valid = 1'b0; f_b_valid = 1'b0;
        r_reset = 1'b0; f_reset = 1'b0;
    endtask

    task automatic test_single_a();
        reset_rr();
        r_a_valid = 1'b1; r_a_addr = 5'd5; r_a_data = 32'h12345678;
        #1;
        checks++; if (r_a_ready !== 1'b1) begin errors++; $display("FAIL single_a_ready: got %b expected 1", r_a_ready); end
        @(posedge clk); #1;
        r_a_valid = 1'b0;
        checks++; if (r_wr !== 1'b0 || r_busy !== 1'b1) begin errors++; $display("FAIL single_edge_k: wr/busy got %b%b expected 01", r_wr, r_busy); end
        @(posedge clk); #1;
        checks++; if (r_wr !== 1'b1) begin errors++; $display("FAIL single_write_reg: got %b expected 1", r_wr); end
        checks++; if (r_waddr !== 5'd5 || r_wdata !== 32'h12345678) begin errors++; $display("FAIL single_addr_data: got %0d/%h expected 5/12345678", r_waddr, r_wdata); end
        checks++; if (r_grant_b !== 1'b0) begin errors++; $display("FAIL single_grant_b: got %b expected 0", r_grant_b); end
        @(posedge clk); #1;
        checks++; if (r_wr !== 1'b0 || r_waddr !== 5'd5 || r_busy !== 1'b0) begin errors++; $display("FAIL single_after: wr=%b addr=%0d busy=%b expected 0/5/0", r_wr, r_waddr, r_busy); end
    endtask

    task automatic test_round_robin();
        logic [4:0] a_list [3];
        logic [4:0] b_list [3];
        logic [4:0] exp_addr;
        logic [31:0] exp_data;
        logic exp_b, a_fire, b_fire;
        int ai, bi, edge_n, n;
        a_list = '{5'd1, 5'd2, 5'd3};
        b_list = '{5'd9, 5'd10, 5'd11};
        ai = 0; bi = 0;
        reset_rr();
        for (int c = 0; c < 9; c++) begin
            r_a_valid = (ai < 3);
            r_a_addr  = (ai < 3) ? a_list[ai] : 5'd0;
            r_a_data  = 32'hA000_0000 | {27'd0, r_a_addr};
            r_b_valid = (bi < 3);
            r_b_addr  = (bi < 3) ? b_list[bi] : 5'd0;
            r_b_data  = 32'hB000_0000 | {27'd0, r_b_addr};
            #1;
            a_fire = r_a_valid && r_a_ready;
            b_fire = r_b_valid && r_b_ready;
            @(posedge clk); #1;
            if (a_fire) ai++;
            if (b_fire) bi++;
            edge_n = c + 1;
            if (edge_n >= 2 && edge_n <= 7) begin
                n = edge_n - 2;
                exp_b = (n % 2) == 1;
                exp_addr = exp_b ? b_list[n/2] : a_list[n/2];
                exp_data = (exp_b ? 32'hB000_0000 : 32'hA000_0000) | {27'd0, exp_addr};
                checks++;
                if (r_wr !== 1'b1 || r_waddr !== exp_addr || r_wdata !== exp_data || r_grant_b !== exp_b) begin
                    errors++;
                    $display("FAIL rr_write_%0d: got wr=%b addr=%0d data=%h gb=%b expected 1/%0d/%h/%b",
                             n, r_wr, r_waddr, r_wdata, r_grant_b, exp_addr, exp_data, exp_b);
                end
            end else begin
                checks++; if (r_wr !== 1'b0) begin errors++; $display("FAIL rr_idle_edge%0d: wr got %b expected 0", edge_n, r_wr); end
            end
        end
        r_a_valid = 1'b0; r_b_valid = 1'b0;
    endtask

    task automatic test_fixed_prio();
        logic [4:0] a_list [2];
        logic [4:0] b_list [4];
        logic [4:0] exp_addr;
        logic [31:0] exp_data;
        logic exp_b, a_fire, b_fire;
        int ai, bi, edge_n;
        a_list = '{5'd4, 5'd5};
        b_list = '{5'd20, 5'd21, 5'd22, 5'd23};
        ai = 0; bi = 0;
        reset_fp();
        for (int c = 0; c < 9; c++) begin
            f_a_valid = (ai < 2);
            f_a_addr  = (ai < 2) ? a_list[ai] : 5'd0;
            f_a_data  = 32'hA000_0000 | {27'd0, f_a_addr};
            f_b_valid = (bi < 4);
            f_b_addr  = (bi < 4) ? b_list[bi] : 5'd0;
            f_b_data  = 32'hB000_0000 | {27'd0, f_b_addr};
            #1;
            if (c >= 1 && c <= 4) begin
                checks++; if (f_a_ready !== 1'b0) begin errors++; $display("FAIL fp_a_blocked_c%0d: a_ready got %b expected 0", c, f_a_ready); end
            end else if (c == 5) begin
                checks++; if (f_a_ready !== 1'b1) begin errors++; $display("FAIL fp_a_released: a_ready got %b expected 1", f_a_ready); end
            end
            a_fire = f_a_valid && f_a_ready;
            b_fire = f_b_valid && f_b_ready;
            @(posedge clk); #1;
            if (a_fire) ai++;
            if (b_fire) bi++;
            edge_n = c + 1;
            if (edge_n >= 2 && edge_n <= 7) begin
                exp_b = (edge_n <= 5);
                exp_addr = exp_b ? b_list[edge_n-2] : a_list[edge_n-6];
                exp_data = (exp_b ? 32'hB000_0000 : 32'hA000_0000) | {27'd0, exp_addr};
                checks++;
                if (f_wr !== 1'b1 || f_waddr !== exp_addr || f_wdata !== exp_data || f_grant_b !== exp_b) begin
                    errors++;
                    $display("FAIL fp_write_edge%0d: got wr=%b addr=%0d data=%h gb=%b expected 1/%0d/%h/%b",
                             edge_n, f_wr, f_waddr, f_wdata, f_grant_b, exp_addr, exp_data, exp_b);
                end
            end else begin
                checks++; if (f_wr !== 1'b0) begin errors++; $display("FAIL fp_idle_edge%0d: wr got %b expected 0", edge_n, f_wr); end
            end
        end
        f_a_valid = 1'b0; f_b_valid = 1'b0;
    endtask

    task automatic test_addr_zero();
        reset_rr();
        r_a_valid = 1'b1; r_a_addr = 5'd0; r_a_data = 32'hFFFFFFFF;
        #1;
        checks++; if (r_a_ready !== 1'b1) begin errors++; $display("FAIL zero_a_ready: got %b expected 1", r_a_ready); end
        @(posedge clk); #1;
        r_a_valid = 1'b0;
        checks++; if (r_busy !== 1'b0) begin errors++; $display("FAIL zero_not_buffered: busy got %b expected 0", r_busy); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (r_wr !== 1'b0) begin errors++; $display("FAIL zero_no_write_%0d: wr got %b expected 0", i, r_wr); end
        end
    endtask

    task automatic test_reset_midop();
        reset_rr();
        r_a_valid = 1'b1; r_a_addr = 5'd12; r_a_data = 32'hC0C0_0012;
        r_b_valid = 1'b1; r_b_addr = 5'd13; r_b_data = 32'hD0D0_0013;
        @(posedge clk); #1;
        r_a_addr = 5'd14; r_a_data = 32'hC0C0_0014; r_b_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (r_wr !== 1'b1 || r_busy !== 1'b1 || r_waddr !== 5'd12) begin errors++; $display("FAIL midop_primed: wr=%b busy=%b addr=%0d expected 1/1/12", r_wr, r_busy, r_waddr); end
        r_reset = 1'b1; r_a_valid = 1'b0; r_b_valid = 1'b0;
        #1;
        checks++; if (r_a_ready !== 1'b0 || r_b_ready !== 1'b0) begin errors++; $display("FAIL midop_ready_in_reset: got %b%b expected 00", r_a_ready, r_b_ready); end
        @(posedge clk); #1;
        r_reset = 1'b0;
        checks++;
        if (r_wr !== 1'b0 || r_waddr !== 5'd0 || r_wdata !== 32'd0 || r_grant_b !== 1'b0 || r_busy !== 1'b0) begin
            errors++;
            $display("FAIL midop_after_reset: wr=%b addr=%0d data=%h gb=%b busy=%b expected all 0", r_wr, r_waddr, r_wdata, r_grant_b, r_busy);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++; if (r_wr !== 1'b0) begin errors++; $display("FAIL midop_stale_write_%0d: wr got %b expected 0", i, r_wr); end
        end
    endtask

    task automatic test_same_addr();
        reset_rr();
        r_a_valid = 1'b1; r_a_addr = 5'd7; r_a_data = 32'h1;
        r_b_valid = 1'b1; r_b_addr = 5'd7; r_b_data = 32'h2;
        #1;
        checks++; if (r_a_ready !== 1'b1 || r_b_ready !== 1'b1) begin errors++; $display("FAIL same_ready: got %b%b expected 11", r_a_ready, r_b_ready); end
        @(posedge clk); #1;
        r_a_valid = 1'b0; r_b_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (r_wr !== 1'b1 || r_waddr !== 5'd7 || r_wdata !== 32'h1 || r_grant_b !== 1'b0) begin errors++; $display("FAIL same_first: wr=%b addr=%0d data=%h gb=%b expected 1/7/1/0", r_wr, r_waddr, r_wdata, r_grant_b); end
        @(posedge clk); #1;
        checks++; if (r_wr !== 1'b1 || r_waddr !== 5'd7 || r_wdata !== 32'h2 || r_grant_b !== 1'b1) begin errors++; $display("FAIL same_second: wr=%b addr=%0d data=%h gb=%b expected 1/7/2/1", r_wr, r_waddr, r_wdata, r_grant_b); end
        @(posedge clk); #1;
        checks++; if (rf[7] !== 32'h2) begin errors++; $display("FAIL same_final_reg7: got %h expected 2", rf[7]); end
        checks++; if (r_wr !== 1'b0) begin errors++; $display("FAIL same_idle: wr got %b expected 0", r_wr); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_a();
        test_round_robin();
        test_fixed_prio();
        test_addr_zero();
        test_reset_midop();
        test_same_addr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_wb_arbiter.md
Name: mips_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: A = ALU result, B = memory load data.
- Each requester has a 1-entry hold buffer and a valid/ready handshake.
- An arbiter grants one buffered entry per cycle into a registered write stage that drives the register file's Write_Reg / W_Addr / W_Data inputs.
- Sits between the execute/memory stages and the register file; replaces the direct ALU-to-W_Data connection.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register address.
- PRIO_MODE, 0, arbitration mode: 0 = round-robin; 1 = fixed priority, B over A.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous active-high reset, sampled on posedge clk.
- a_valid  in  1  ALU requester has a write.
- a_ready  out  1  A buffer can accept this cycle.
- a_addr  in  ADDR_W  ALU destination register.
- a_data  in  DATA_W  ALU result.
- b_valid  in  1  memory requester has a write.
- b_ready  out  1  B buffer can accept this cycle.
- b_addr  in  ADDR_W  load destination register.
- b_data  in  DATA_W  load data.
- Write_Reg  out  1  registered write enable to register file.
- W_Addr  out  ADDR_W  registered write address.
- W_Data  out  DATA_W  registered write data.
- grant_b  out  1  registered; 1 when the current write came from B.
- busy  out  1  combinational; any buffer full or Write_Reg high.

Behaviour:
- Reset is synchronous and active-high on clk. At the reset edge: both buffers empty, Write_Reg=0, W_Addr=0, W_Data=0, grant_b=0, round-robin pointer = A-next. While reset is high, a_ready=b_ready=0. Reset mid-operation discards buffered and in-flight writes; no Write_Reg pulse follows.
- Accept: a transfer occurs when x_valid && x_ready at a posedge.
  - Address 0 transfers are accepted and discarded: not buffered, never written.
  - Nonzero-address transfers load the buffer (addr, data) and set it full.
- x_ready = !x_full || x_grant. The same-cycle refill of a buffer being granted is allowed.
- Arbitration, combinational each cycle, over full buffers only:
  - One full buffer: that one is granted.
  - Both full, PRIO_MODE=0: grant the side the pointer names; the pointer flips to the other side after every grant while both are full. With a single full buffer, the pointer points to the other side after the grant.
  - Both full, PRIO_MODE=1: B always wins; A waits with no bound.
- Write stage, registered:
  - On a grant edge: Write_Reg=1, W_Addr/W_Data = granted entry, grant_b = (granted==B), granted buffer cleared unless refilled the same edge.
  - With no grant: Write_Reg=0; W_Addr/W_Data hold their last values.
- Latency: transfer at edge k -> earliest Write_Reg high in cycle after edge k+1 -> register file written at edge k+2. Throughput is one write per cycle sustained.
- Ordering:
  - Per requester, writes reach the register file in acceptance order.
  - Across requesters, order is the grant order only. Same-address writes from A and B pending together: the later-granted one wins.
- Simultaneous accept on both sides plus a grant: legal; each buffer updates independently.
- No combinational path from a_valid/b_valid to a_ready/b_ready except through the grant of already-full buffers.

Test Plan:
- Reset then single A write (a_addr=5, a_data=0x12345678) -> Write_Reg pulses exactly 1 cycle, two edges after the transfer, W_Addr=5, W_Data=0x12345678, grant_b=0.
- A and B both valid every cycle, PRIO_MODE=0, distinct addresses (A: 1,2,3; B: 9,10,11) -> writes strictly alternate, Write_Reg high every cycle once primed, and each side's order is preserved.
- PRIO_MODE=1, both held valid -> B granted every cycle, a_ready stays 0 after the first A accept; dropping b_valid lets A's buffered write emerge next cycle.
- Write to address 0 (a_addr=0, a_data=0xFFFFFFFF) -> a_ready=1, transfer accepted, Write_Reg never asserts.
- Buffers full and Write_Reg high, then reset asserted for 1 cycle -> Write_Reg=0, W_Addr=0, W_Data=0, busy=0 after the reset edge, and no stale write afterwards.
- Same address from both (A addr=7 data=0x1, B addr=7 data=0x2, same cycle, pointer=A) -> write 7<-0x1 then 7<-0x2; final register 7 value is 0x2.
